dmem_byte_sequencer: RTL and testbench
======================================

# dmem_byte_sequencer

Sequencer and arbiter in front of the byte-organised data memory (256 x 8-bit array). It shares the memory between two 64-bit requesters, the pipeline MEM stage (cpu) and the program/data loader (ldr). Each doubleword access is serialised into eight byte beats, little-endian. The MEM stage is stalled until its access completes.

## Interface
- ADDR_W, 8, byte-address width of the memory (depth 2^ADDR_W)
- DATA_W, 64, requester data width; beats = DATA_W/8
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- cpu_req / ldr_req  in  1  request; held high until the matching done pulse
- cpu_we / ldr_we  in  1  1 = write, 0 = read
- cpu_addr / ldr_addr  in  64  byte address of the doubleword
- cpu_wdata / ldr_wdata  in  DATA_W  write data
- cpu_rdata / ldr_rdata  out  DATA_W  read data, held until that requester's next read
- cpu_done / ldr_done  out  1  one-cycle completion pulse
- cpu_err / ldr_err  out  1  one-cycle pulse with done on a rejected access
- cpu_stall  out  1  cpu_req & ~cpu_done (combinational)
- mem_addr  out  ADDR_W  byte address to the array
- mem_wdata  out  8  byte to write
- mem_we  out  1  byte write strobe, committed on the rising clk edge
- mem_re  out  1  byte read enable
- mem_rdata  in  8  byte read data, combinational from mem_addr in the same cycle
- busy  out  1  high whenever the state is not IDLE

## Operation
- States: IDLE, XFER, DONE.
- IDLE: if any req is high, grant one at the clock edge. Latch the owner, we, addr and wdata, and clear the beat counter.
  - Both requesting: round-robin, granting the requester not granted last.
  - After reset, last = ldr, so the cpu wins the first tie.
- Validity check at grant:
  - Reject if addr[2:0] != 0 (misaligned).
  - Reject if addr[63:ADDR_W] != 0 (out of range).
  - On reject, go directly to DONE with err set. No mem_re or mem_we, and the owner's rdata is unchanged.
- XFER: beat i = 0..7.
  - mem_addr = latched_addr[ADDR_W-1:0] + i. The sum cannot wrap because the address is aligned and in range.
  - Write: mem_we = 1, mem_wdata = wdata[8i+7:8i].
  - Read: mem_re = 1. At the end of the beat, mem_rdata is captured into an assembly register at byte i.
  - After beat 7, go to DONE.
- DONE: for one cycle, assert owner_done and owner_err (if rejected).
  - On a good read, the owner's rdata is loaded from the assembly register on entry to DONE, so it is valid in the DONE cycle.
  - Then go to IDLE.
- Requester inputs are ignored outside IDLE. Changes to addr, wdata or we mid-transfer have no effect.
- A requester must drop req in the cycle after done. A req still high in the following IDLE cycle is treated as a new request.
- The non-owner's outputs are unaffected by the owner's transaction.
- mem_we and mem_re are never both high, and both are 0 outside XFER.

## Timing
- Reset (asynchronous, any state):
  - State returns to IDLE; beat counter = 0; last = ldr.
  - All outputs are 0, including both rdata registers.
  - Bytes already written by a partial write remain in memory; there is no rollback.
- Good access, with req high in IDLE cycle t:
  - XFER occupies cycles t+1..t+8.
  - done is high in cycle t+9.
  - IDLE resumes in cycle t+10.
  - Latency is 10 cycles from request to the IDLE that accepts the next request.
- Rejected access: grant at t, DONE at t+1, IDLE at t+2.
- Steady contention: grants alternate cpu, ldr, cpu, ... with one transaction per 10 cycles.
- cpu_stall is high from the first cycle cpu_req is high through the cycle before cpu_done.
  - The cpu sees the stall fall in the done cycle and advances on that edge.
- busy is high in cycles t+1..t+9.

## Test plan
- Reset, then cpu read at addr 0x00 with memory[0..7] = 03,00..00:
  - mem_re high for 8 cycles on addresses 0..7.
  - cpu_done at cycle 10 with cpu_rdata = 64'h3.
  - cpu_stall low in the done cycle.
- ldr write addr 0x10, wdata 64'h0807060504030201, then cpu read of 0x10:
  - Bytes 01..08 are written to 0x10..0x17 in order.
  - cpu_rdata = 64'h0807060504030201.
- cpu and ldr both assert in the same IDLE cycle after reset:
  - cpu is granted first, ldr second.
  - With both held, subsequent grants alternate; ldr_done comes 10 cycles after cpu_done.
- cpu read at addr 0x0C (misaligned) and at 0x100 (out of range):
  - done and err in the cycle after the grant.
  - No mem_re or mem_we.
  - cpu_rdata retains its previous value.
- reset asserted during beat 3 of an ldr write of 64'hFFFF_FFFF_FFFF_FFFF to 0x18:
  - Immediately idle, with all outputs 0.
  - Bytes 0x18..0x1A = FF; bytes 0x1B..0x1F unchanged.
- cpu changes cpu_addr and cpu_wdata during XFER:
  - Memory receives only the values latched at grant.

Source files
------------

// File: rtl/dmem_byte_sequencer.sv
// Byte-serialising sequencer and round-robin arbiter between the pipeline MEM
// stage (cpu) and the loader (ldr) in front of a byte-wide data memory.
// Each doubleword access becomes Beats little-endian byte beats.
module dmem_byte_sequencer #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [63:0]       cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_done,
  output logic              cpu_err,
  output logic              cpu_stall,
  input  logic              ldr_req,
  input  logic              ldr_we,
  input  logic [63:0]       ldr_addr,
  input  logic [DATA_W-1:0] ldr_wdata,
  output logic [DATA_W-1:0] ldr_rdata,
  output logic              ldr_done,
  output logic              ldr_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [7:0]        mem_rdata,
  output logic              busy
);

  localparam int unsigned Beats = DATA_W / 8;
  localparam int unsigned BeatW = $clog2(Beats);

  typedef enum logic [1:0] {StIdle, StXfer, StDone} state_e;

  state_e              state_q, state_d;
  logic                owner_q;  // 1 = ldr owns the current transaction
  logic                last_q;   // 1 = ldr was granted last
  logic                we_q;
  logic                err_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   asm_q, asm_d;
  logic [BeatW-1:0]    beat_q;
  logic [DATA_W-1:0]   cpu_rdata_q, ldr_rdata_q;

  logic                any_req;
  logic                gnt_ldr;
  logic                gnt_we;
  logic [63:0]         gnt_addr;
  logic [DATA_W-1:0]   gnt_wdata;
  logic                gnt_ok;
  logic                last_beat;

  // Arbitration and validity of the requester that would be granted now
  always_comb begin
    any_req   = cpu_req | ldr_req;
    gnt_ldr   = (cpu_req & ldr_req) ? ~last_q : ldr_req;
    gnt_we    = gnt_ldr ? ldr_we : cpu_we;
    gnt_addr  = gnt_ldr ? ldr_addr : cpu_addr;
    gnt_wdata = gnt_ldr ? ldr_wdata : cpu_wdata;
    gnt_ok    = (gnt_addr[BeatW-1:0] == '0) && (gnt_addr[63:ADDR_W] == '0);
    last_beat = (beat_q == BeatW'(Beats - 1));
    // Read assembly with the current beat's byte merged in
    asm_d                        = asm_q;
    asm_d[{beat_q, 3'b000} +: 8] = mem_rdata;
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; rejected accesses skip the transfer entirely
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (any_req) state_d = gnt_ok ? StXfer : StDone;
      StXfer:  if (last_beat) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Grant latch, beat counter, read assembly and per-requester read data
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner_q     <= 1'b0;
      last_q      <= 1'b1;
      we_q        <= 1'b0;
      err_q       <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      asm_q       <= '0;
      beat_q      <= '0;
      cpu_rdata_q <= '0;
      ldr_rdata_q <= '0;
    end else if (state_q == StIdle) begin
      if (any_req) begin
        owner_q <= gnt_ldr;
        last_q  <= gnt_ldr;
        we_q    <= gnt_we;
        err_q   <= ~gnt_ok;
        addr_q  <= gnt_addr[ADDR_W-1:0];
        wdata_q <= gnt_wdata;
        beat_q  <= '0;
      end
    end else if (state_q == StXfer) begin
      beat_q <= beat_q + 1'b1;
      if (!we_q) begin
        asm_q <= asm_d;
        // Load the owner's result as we enter DONE so it is valid in that cycle
        if (last_beat) begin
          if (owner_q) ldr_rdata_q <= asm_d;
          else         cpu_rdata_q <= asm_d;
        end
      end
    end
  end

  // Memory strobes, completion pulses and status
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    cpu_done  = 1'b0;
    cpu_err   = 1'b0;
    ldr_done  = 1'b0;
    ldr_err   = 1'b0;
    if (state_q == StXfer) begin
      mem_addr = addr_q + ADDR_W'(beat_q);
      mem_we   = we_q;
      mem_re   = ~we_q;
      if (we_q) mem_wdata = wdata_q[{beat_q, 3'b000} +: 8];
    end
    if (state_q == StDone) begin
      cpu_done = ~owner_q;
      cpu_err  = ~owner_q & err_q;
      ldr_done = owner_q;
      ldr_err  = owner_q & err_q;
    end
    busy      = (state_q != StIdle);
    cpu_stall = cpu_req & ~cpu_done;
    cpu_rdata = cpu_rdata_q;
    ldr_rdata = ldr_rdata_q;
  end

endmodule

// File: tb/tb_dmem_byte_sequencer.sv
// Self-checking bench for dmem_byte_sequencer: a byte memory model, a
// transaction-level reference (byte array plus expected per-requester read
// data and round-robin pointer) and a per-cycle timing expectation.
module tb_dmem_byte_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we, cpu_done, cpu_err, cpu_stall;
  logic [63:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        ldr_req, ldr_we, ldr_done, ldr_err;
  logic [63:0] ldr_addr, ldr_wdata, ldr_rdata;
  logic [7:0]  mem_addr, mem_wdata, mem_rdata;
  logic        mem_we, mem_re, busy;

  logic [7:0]  mem     [256];
  logic [7:0]  ref_mem [256];
  logic [63:0] exp_rd  [2];   // 0 = cpu, 1 = ldr
  bit          last_ldr;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  dmem_byte_sequencer #(.ADDR_W(8), .DATA_W(64)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_done(cpu_done), .cpu_err(cpu_err), .cpu_stall(cpu_stall),
    .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
    .ldr_rdata(ldr_rdata), .ldr_done(ldr_done), .ldr_err(ldr_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_mem_we"}, mem_we, 0);
    check({tag, "_mem_re"}, mem_re, 0);
    check({tag, "_mem_addr"}, mem_addr, 0);
    check({tag, "_mem_wdata"}, mem_wdata, 0);
    check({tag, "_done"}, {cpu_done, cpu_err, ldr_done, ldr_err, cpu_stall}, 0);
    check({tag, "_cpu_rdata"}, cpu_rdata, 0);
    check({tag, "_ldr_rdata"}, ldr_rdata, 0);
  endtask

  function automatic logic [63:0] rand_addr();
    logic [63:0] a;
    int r;
    r = $urandom_range(0, 9);
    a = {56'd0, 5'($urandom_range(0, 31)), 3'd0};
    if (r == 0) a[2:0] = 3'($urandom_range(1, 7));
    else if (r == 1) a[8 + $urandom_range(0, 55)] = 1'b1;
    return a;
  endfunction

  // One request round; both requesters may start in the same IDLE cycle.
  // Expected timing: good access done 9 cycles after grant, reject 1 cycle;
  // the waiting requester is granted in the IDLE cycle after the first done.
  task automatic run(input bit c_en, input bit c_we, input logic [63:0] c_addr,
                     input logic [63:0] c_wdata, input bit l_en, input bit l_we,
                     input logic [63:0] l_addr, input logic [63:0] l_wdata,
                     input bit scramble);
    bit          en [2];
    bit          we [2];
    bit          ok [2];
    logic [63:0] ad [2];
    logic [63:0] wd [2];
    logic [63:0] old_rd [2];
    logic [63:0] new_rd [2];
    int          g [2];
    int          d [2];
    int          first, last_n, act, beat, w;
    bit          exp_busy, cdone, ldone;
    logic [7:0]  ea;

    en = '{c_en, l_en}; we = '{c_we, l_we}; ad = '{c_addr, l_addr}; wd = '{c_wdata, l_wdata};
    for (int i = 0; i < 2; i++) begin
      ok[i] = 1'b0; g[i] = -100; d[i] = -100;
      old_rd[i] = exp_rd[i]; new_rd[i] = exp_rd[i];
    end
    first  = (c_en && l_en) ? (last_ldr ? 0 : 1) : (c_en ? 0 : 1);
    last_n = 0;
    for (int k = 0; k < 2; k++) begin
      w = (k == 0) ? first : 1 - first;
      if (en[w]) begin
        ok[w] = (ad[w][2:0] == 3'd0) && (ad[w][63:8] == 56'd0);
        g[w]  = (k == 0) ? 0 : d[1 - w] + 1;
        d[w]  = g[w] + (ok[w] ? 9 : 1);
        if (ok[w]) begin
          for (int b = 0; b < 8; b++) begin
            if (we[w]) ref_mem[ad[w][7:0] + 8'(b)] = wd[w][8*b +: 8];
            else       exp_rd[w][8*b +: 8] = ref_mem[ad[w][7:0] + 8'(b)];
          end
        end
        new_rd[w] = exp_rd[w];
        last_ldr  = (w == 1);
        last_n    = d[w];
      end
    end

    cpu_req = c_en; cpu_we = c_we; cpu_addr = c_addr; cpu_wdata = c_wdata;
    ldr_req = l_en; ldr_we = l_we; ldr_addr = l_addr; ldr_wdata = l_wdata;

    for (int n = 0; n <= last_n + 1; n++) begin
      if (n > 0) @(posedge clk);
      #1;
      if (en[0] && n == d[0] + 1) cpu_req = 1'b0;
      if (en[1] && n == d[1] + 1) ldr_req = 1'b0;
      if (scramble && n >= 1 && n <= 8) begin
        cpu_addr  = {$urandom, $urandom};
        cpu_wdata = {$urandom, $urandom};
        cpu_we    = 1'($urandom_range(0, 1));
      end
      #1;
      act = -1; beat = 0; exp_busy = 1'b0;
      for (int i = 0; i < 2; i++) begin
        if (en[i] && ok[i] && n > g[i] && n <= g[i] + 8) begin
          act = i; beat = n - g[i] - 1;
        end
        if (en[i] && n > g[i] && n <= d[i]) exp_busy = 1'b1;
      end
      cdone = en[0] && (n == d[0]);
      ldone = en[1] && (n == d[1]);
      check($sformatf("busy@%0d", n), busy, exp_busy);
      check($sformatf("mem_re@%0d", n), mem_re, (act >= 0) && !we[act]);
      check($sformatf("mem_we@%0d", n), mem_we, (act >= 0) && we[act]);
      if (act >= 0) begin
        ea = ad[act][7:0] + 8'(beat);
        check($sformatf("mem_addr@%0d", n), mem_addr, ea);
        if (we[act]) check($sformatf("mem_wdata@%0d", n), mem_wdata, wd[act][8*beat +: 8]);
      end
      check($sformatf("cpu_done@%0d", n), cpu_done, cdone);
      check($sformatf("cpu_err@%0d", n), cpu_err, cdone && !ok[0]);
      check($sformatf("ldr_done@%0d", n), ldr_done, ldone);
      check($sformatf("ldr_err@%0d", n), ldr_err, ldone && !ok[1]);
      check($sformatf("cpu_stall@%0d", n), cpu_stall, cpu_req && !cdone);
      check($sformatf("cpu_rdata@%0d", n), cpu_rdata,
            (en[0] && n >= d[0]) ? new_rd[0] : old_rd[0]);
      check($sformatf("ldr_rdata@%0d", n), ldr_rdata,
            (en[1] && n >= d[1]) ? new_rd[1] : old_rd[1]);
    end
  endtask

  task automatic reset_pulse();
    reset = 1'b1;
    #2;
    reset = 1'b0;
    last_ldr = 1'b1;
    exp_rd = '{64'd0, 64'd0};
  endtask

  initial begin
    reset = 1'b1;
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    ldr_req = 0; ldr_we = 0; ldr_addr = 0; ldr_wdata = 0;
    for (int i = 0; i < 256; i++) begin
      mem[i] = 8'($urandom);
      ref_mem[i] = mem[i];
    end
    for (int i = 0; i < 8; i++) begin
      mem[i] = (i == 0) ? 8'h03 : 8'h00;
      ref_mem[i] = mem[i];
    end
    last_ldr = 1'b1;
    exp_rd = '{64'd0, 64'd0};
    #12;
    check_all_zero("reset");
    @(posedge clk); #1;
    reset = 1'b0;

    // Basic read, loader write then cpu read-back
    run(1, 0, 64'h0, 64'h0, 0, 0, 64'h0, 64'h0, 0);
    check("first_read", cpu_rdata, 64'h3);
    run(0, 0, 64'h0, 64'h0, 1, 1, 64'h10, 64'h0807060504030201, 0);
    run(1, 0, 64'h10, 64'h0, 0, 0, 64'h0, 64'h0, 0);
    check("readback_10", cpu_rdata, 64'h0807060504030201);

    // Contention after reset: cpu first; then ldr wins after a cpu-only grant
    reset_pulse();
    run(1, 0, 64'h10, 64'h0, 1, 0, 64'h0, 64'h0, 0);
    run(1, 1, 64'h20, 64'h1122334455667788, 0, 0, 64'h0, 64'h0, 0);
    run(1, 0, 64'h20, 64'h0, 1, 0, 64'h20, 64'h0, 0);
    run(1, 0, 64'h0, 64'h0, 1, 0, 64'h10, 64'h0, 0);

    // Rejected accesses leave rdata untouched and never touch memory
    run(1, 0, 64'h0C, 64'h0, 0, 0, 64'h0, 64'h0, 0);
    run(1, 0, 64'h100, 64'h0, 0, 0, 64'h0, 64'h0, 0);
    check("reject_hold", cpu_rdata, 64'h3);

    // Reset during beat 3 of a loader write to 0x18
    ldr_req = 1; ldr_we = 1; ldr_addr = 64'h18; ldr_wdata = '1;
    repeat (4) @(posedge clk);
    #1;
    check("beat3_addr", mem_addr, 8'h1B);
    check("beat3_we", mem_we, 1);
    reset = 1'b1;
    #1;
    check_all_zero("midreset");
    ldr_req = 0;
    #1;
    reset = 1'b0;
    last_ldr = 1'b1;
    exp_rd = '{64'd0, 64'd0};
    for (int i = 8'h18; i <= 8'h1A; i++) ref_mem[i] = 8'hFF;
    for (int i = 8'h18; i <= 8'h1F; i++) check($sformatf("partial_%0h", i), mem[i], ref_mem[i]);

    // Inputs changed mid-transfer must not affect the write
    run(1, 1, 64'h40, 64'hDEADBEEFCAFEF00D, 0, 0, 64'h0, 64'h0, 1);
    run(1, 0, 64'h40, 64'h0, 0, 0, 64'h0, 64'h0, 0);
    check("scramble_rd", cpu_rdata, 64'hDEADBEEFCAFEF00D);

    // Randomised traffic
    for (int it = 0; it < 40; it++) begin
      int mode;
      mode = $urandom_range(0, 2);
      run(mode != 1, 1'($urandom_range(0, 1)), rand_addr(), {$urandom, $urandom},
          mode != 0, 1'($urandom_range(0, 1)), rand_addr(), {$urandom, $urandom},
          (mode == 0) && ($urandom_range(0, 3) == 0));
    end

    for (int i = 0; i < 256; i++) check($sformatf("mem_%0h", i), mem[i], ref_mem[i]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
